// File: rtl/note_renderer.sv
// Note renderer: scrolls NUM_NOTES note slots once per frame and composites
// their rectangles over the ledger gray through a 2-stage pixel pipeline.
module note_renderer #(
   parameter int NUM_NOTES   = 8,
   parameter int COLOR_W     = 4,
   parameter int PITCH_W     = 4,
   parameter int NOTE_W      = 16,
   parameter int NOTE_H      = 8,
   parameter int PITCH_STEP  = 4,
   parameter int STAFF_TOP   = 100,
   parameter int SCROLL_STEP = 2,
   parameter int H_VISIBLE   = 640
) (
   input  logic                         Clk,
   input  logic                         Reset,
   input  logic [9:0]                   DrawX,
   input  logic [9:0]                   DrawY,
   input  logic                         blank,
   input  logic                         vs,
   input  logic [COLOR_W-1:0]           gray,
   input  logic                         wr_en,
   output logic                         wr_ready,
   input  logic [$clog2(NUM_NOTES)-1:0] wr_slot,
   input  logic [PITCH_W-1:0]           wr_pitch,
   input  logic [3*COLOR_W-1:0]         wr_rgb,
   output logic [NUM_NOTES-1:0]         active_mask,
   output logic [COLOR_W-1:0]           red,
   output logic [COLOR_W-1:0]           green,
   output logic [COLOR_W-1:0]           blue
);
   localparam int IDX_W = $clog2(NUM_NOTES);

   typedef enum logic [0:0] {IDLE = 1'b0, SCROLL = 1'b1} state_t;

   state_t               state;
   logic [IDX_W-1:0]     idx;
   logic                 vs_prev;
   logic                 frame_start;
   logic [10:0]          x     [NUM_NOTES];
   logic [PITCH_W-1:0]   pitch [NUM_NOTES];
   logic [3*COLOR_W-1:0] rgb   [NUM_NOTES];

   logic                 hit_any;
   logic [IDX_W-1:0]     hit_sel;
   logic                 hit_d;
   logic [IDX_W-1:0]     hit_idx_d;
   logic                 blank_d;
   logic [COLOR_W-1:0]   gray_d;

   assign frame_start = vs_prev & ~vs;

   // Slot storage, write port and scroll FSM; a write can only land in IDLE
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state       <= IDLE;
         idx         <= '0;
         vs_prev     <= 1'b1;
         wr_ready    <= 1'b1;
         active_mask <= '0;
         for (int i = 0; i < NUM_NOTES; i++) begin
            x[i]     <= 11'd0;
            pitch[i] <= '0;
            rgb[i]   <= '0;
         end
      end else begin
         vs_prev <= vs;
         if (wr_en && wr_ready) begin
            x[wr_slot]           <= 11'(H_VISIBLE);
            pitch[wr_slot]       <= wr_pitch;
            rgb[wr_slot]         <= wr_rgb;
            active_mask[wr_slot] <= 1'b1;
         end
         case (state)
            IDLE: begin
               if (frame_start) begin
                  state    <= SCROLL;
                  idx      <= '0;
                  wr_ready <= 1'b0;
               end
            end
            SCROLL: begin
               if (active_mask[idx] && (x[idx] < 11'(SCROLL_STEP))) begin
                  active_mask[idx] <= 1'b0;
               end else if (active_mask[idx]) begin
                  x[idx] <= x[idx] - 11'(SCROLL_STEP);
               end
               if (idx == IDX_W'(NUM_NOTES - 1)) begin
                  state    <= IDLE;
                  wr_ready <= 1'b1;
               end else begin
                  idx <= idx + IDX_W'(1);
               end
            end
            default: begin
               state    <= IDLE;
               wr_ready <= 1'b1;
            end
         endcase
      end
   end

   // Hit test against every slot; scanning downward lets the lowest index win
   always_comb begin
      logic [10:0] top;
      logic [10:0] px_x;
      logic [10:0] px_y;
      hit_any = 1'b0;
      hit_sel = '0;
      top     = 11'd0;
      px_x    = 11'(DrawX);
      px_y    = 11'(DrawY);
      for (int i = NUM_NOTES - 1; i >= 0; i--) begin
         top = 11'(STAFF_TOP) + 11'(pitch[i]) * 11'(PITCH_STEP);
         if (active_mask[i] && (px_x >= x[i]) && (px_x < x[i] + 11'(NOTE_W)) &&
             (px_y >= top) && (px_y < top + 11'(NOTE_H))) begin
            hit_any = 1'b1;
            hit_sel = IDX_W'(i);
         end else begin
            hit_any = hit_any;
            hit_sel = hit_sel;
         end
      end
   end

   // Pixel pipeline: stage 1 holds the hit decision, stage 2 the final colour
   always_ff @(posedge Clk) begin
      if (Reset) begin
         hit_d     <= 1'b0;
         hit_idx_d <= '0;
         blank_d   <= 1'b0;
         gray_d    <= '0;
         red       <= '0;
         green     <= '0;
         blue      <= '0;
      end else begin
         hit_d     <= hit_any;
         hit_idx_d <= hit_sel;
         blank_d   <= blank;
         gray_d    <= gray;
         if (!blank_d) begin
            red   <= '0;
            green <= '0;
            blue  <= '0;
         end else if (hit_d) begin
            red   <= rgb[hit_idx_d][3*COLOR_W-1:2*COLOR_W];
            green <= rgb[hit_idx_d][2*COLOR_W-1:COLOR_W];
            blue  <= rgb[hit_idx_d][COLOR_W-1:0];
         end else begin
            red   <= gray_d;
            green <= gray_d;
            blue  <= gray_d;
         end
      end
   end
endmodule

// File: tb/tb_note_renderer.sv
// Scoreboard bench for note_renderer: a behavioural slot model predicts each
// pixel, expectations are queued at drive time and popped when the colour emerges.
module tb_note_renderer;
   localparam int N = 8;

   logic        clk = 1'b0;
   logic        Reset;
   logic [9:0]  DrawX, DrawY;
   logic        blank, vs;
   logic [3:0]  gray;
   logic        wr_en;
   logic        wr_ready;
   logic [2:0]  wr_slot;
   logic [3:0]  wr_pitch;
   logic [11:0] wr_rgb;
   logic [7:0]  active_mask;
   logic [3:0]  red, green, blue;

   int          checks = 0;
   int          errors = 0;
   logic [11:0] sb [$];

   bit          m_act [N];
   int          m_x   [N];
   int          m_pit [N];
   logic [11:0] m_rgb [N];

   always #5 clk = ~clk;

   note_renderer dut (
      .Clk(clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
      .vs(vs), .gray(gray), .wr_en(wr_en), .wr_ready(wr_ready), .wr_slot(wr_slot),
      .wr_pitch(wr_pitch), .wr_rgb(wr_rgb), .active_mask(active_mask),
      .red(red), .green(green), .blue(blue)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [11:0] model_px(input int px, input int py, input logic b,
                                            input logic [3:0] g);
      if (!b) return 12'h000;
      for (int i = 0; i < N; i++) begin
         int top;
         top = 100 + m_pit[i] * 4;
         if (m_act[i] && px >= m_x[i] && px < m_x[i] + 16 && py >= top && py < top + 8)
            return m_rgb[i];
      end
      return {g, g, g};
   endfunction

   task automatic model_scroll();
      for (int i = 0; i < N; i++) begin
         if (m_act[i] && m_x[i] < 2) m_act[i] = 1'b0;
         else if (m_act[i]) m_x[i] = m_x[i] - 2;
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < N; i++) begin
         m_act[i] = 1'b0; m_x[i] = 0; m_pit[i] = 0; m_rgb[i] = 12'h000;
      end
   endtask

   function automatic logic [7:0] model_mask();
      logic [7:0] m;
      for (int i = 0; i < N; i++) m[i] = m_act[i];
      return m;
   endfunction

   task automatic px(input string tag, input int x_, input int y_, input logic b,
                     input logic [3:0] g);
      @(negedge clk);
      DrawX = 10'(x_); DrawY = 10'(y_); blank = b; gray = g;
      sb.push_back(model_px(x_, y_, b, g));
      @(posedge clk);
      @(posedge clk);
      #1;
      check(tag, {red, green, blue}, sb.pop_front());
   endtask

   task automatic frame();
      @(negedge clk);
      vs = 1'b0;
      repeat (N + 3) @(negedge clk);
      vs = 1'b1;
      @(negedge clk);
      model_scroll();
   endtask

   task automatic frames(input int n);
      for (int k = 0; k < n; k++) frame();
   endtask

   task automatic wr(input int s, input int p, input logic [11:0] c);
      int n;
      n = 0;
      @(negedge clk);
      wr_en = 1'b1; wr_slot = 3'(s); wr_pitch = 4'(p); wr_rgb = c;
      while (!wr_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!wr_ready) check("wr_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1;
      wr_en = 1'b0;
      m_act[s] = 1'b1; m_x[s] = 640; m_pit[s] = p; m_rgb[s] = c;
      check("wr_mask", 32'(active_mask), 32'(model_mask()));
   endtask

   initial begin
      int low_cnt;
      Reset = 1'b1; DrawX = 10'd0; DrawY = 10'd0; blank = 1'b1; gray = 4'd5; vs = 1'b1;
      wr_en = 1'b0; wr_slot = 3'd0; wr_pitch = 4'd0; wr_rgb = 12'h000;
      model_clear();
      repeat (2) @(posedge clk);
      #1;
      check("rst_rgb", 32'({red, green, blue}), 32'd0);
      check("rst_mask", 32'(active_mask), 32'd0);
      check("rst_ready", 32'(wr_ready), 32'd1);
      @(negedge clk);
      Reset = 1'b0;
      px("bg_gray", 10, 10, 1'b1, 4'd5);

      // Basic hit after 10 frames of scrolling
      wr(0, 2, 12'hF00);
      frames(10);
      px("hit_in", 620, 108, 1'b1, 4'd5);
      px("hit_right", 636, 108, 1'b1, 4'd5);
      px("hit_below", 620, 116, 1'b1, 4'd5);
      px("hit_corner", 635, 115, 1'b1, 4'd3);
      px("hit_left", 619, 108, 1'b1, 4'd3);

      // Expiry at the left edge
      frames(310);
      px("x0_hit", 0, 108, 1'b1, 4'd6);
      check("x0_mask", 32'(active_mask), 32'h01);
      frame();
      check("exp_mask", 32'(active_mask), 32'h00);
      px("exp_gray", 0, 108, 1'b1, 4'd6);

      // Priority between overlapping slots
      wr(1, 0, 12'h0F0);
      frames(4);
      wr(3, 0, 12'h00F);
      px("prio_both", 640, 100, 1'b1, 4'd2);
      px("prio_s3", 650, 100, 1'b1, 4'd2);
      frames(316);
      px("prio_late", 10, 102, 1'b1, 4'd2);
      frame();
      check("prio_mask", 32'(active_mask), 32'h08);
      px("prio_after", 10, 102, 1'b1, 4'd2);
      px("blank_hit", 10, 102, 1'b0, 4'd2);

      // Held write across a frame start
      @(negedge clk);
      vs = 1'b0;
      @(negedge clk);
      model_scroll();
      wr_en = 1'b1; wr_slot = 3'd2; wr_pitch = 4'd5; wr_rgb = 12'hA5C;
      low_cnt = 1;
      for (int k = 0; k < 50 && !wr_ready; k++) begin
         @(negedge clk);
         if (!wr_ready) low_cnt++;
      end
      check("ready_low", 32'(low_cnt), 32'd8);
      @(posedge clk);
      #1;
      wr_en = 1'b0;
      vs = 1'b1;
      m_act[2] = 1'b1; m_x[2] = 640; m_pit[2] = 5; m_rgb[2] = 12'hA5C;
      check("held_mask", 32'(active_mask), 32'(model_mask()));
      px("held_x640", 640, 120, 1'b1, 4'd1);
      px("held_x639", 639, 120, 1'b1, 4'd1);
      frame();
      px("held_next", 638, 120, 1'b1, 4'd1);

      // Reset in the middle of a scroll pass
      @(negedge clk);
      vs = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("mid_scroll", 32'(wr_ready), 32'd0);
      Reset = 1'b1;
      vs = 1'b1;
      @(posedge clk);
      #1;
      check("rst2_mask", 32'(active_mask), 32'd0);
      check("rst2_ready", 32'(wr_ready), 32'd1);
      @(negedge clk);
      Reset = 1'b0;
      model_clear();
      px("rst2_gray", 638, 120, 1'b1, 4'd9);
      check("sb_empty", 32'(sb.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
